// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave oven datapath: state width and the
// state codes consumed by the controller, countdown timer and display decoder.
package microwave_pkg;

   localparam int unsigned STATE_W = 3;

   // Codes 4..7 are unused; the controller recovers from them to IDLE.
   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      COOK  = 3'd1,
      PAUSE = 3'd2,
      DONE  = 3'd3
   } state_t;

endpackage

// File: rtl/microwave_controller_button_sync.sv
// button_sync: two-flop synchronizer for an asynchronous level, plus a
// falling-edge detector producing a single-cycle pulse per 1->0 transition.
//   clock     : system clock
//   clearn    : asynchronous active-low reset, all flops forced to RESET_VAL
//   async_in  : raw asynchronous input
//   level     : synchronized level (two clocks behind async_in)
//   press     : one-cycle pulse when the synchronized level falls
module button_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clock,
   input  logic clearn,
   input  logic async_in,
   output logic level,
   output logic press
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         meta <= RESET_VAL;
         sync <= RESET_VAL;
         prev <= RESET_VAL;
      end else begin
         meta <= async_in;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign press = prev & ~sync;

endmodule

// File: rtl/microwave_controller.sv
// microwave_controller: control FSM in front of the countdown timer.
// Turns start/stop buttons and the door switch into timer control, drives
// the magnetron, an end-of-cook beeper and a display state code.
//   clock        : system clock, rising edge
//   clearn       : asynchronous active-low reset
//   startn       : start button, active-low, asynchronous
//   stopn        : stop/cancel button, active-low, asynchronous
//   door_closed  : door switch level, 1 = closed, asynchronous
//   timer_zero   : timer all-digits-zero flag, synchronous
//   mag_on       : magnetron on / timer enable
//   timer_loadn  : active-low timer load strobe (0 = accept keypad digits)
//   timer_clear  : one-cycle timer clear on a stop-initiated return to IDLE
//   beep         : end-of-cook buzzer, high BEEP_CYCLES cycles
//   state_out    : current state code
module microwave_controller
   import microwave_pkg::*;
#(
   parameter int unsigned BEEP_CYCLES = 4
) (
   input  logic               clock,
   input  logic               clearn,
   input  logic               startn,
   input  logic               stopn,
   input  logic               door_closed,
   input  logic               timer_zero,
   output logic               mag_on,
   output logic               timer_loadn,
   output logic               timer_clear,
   output logic               beep,
   output logic [STATE_W-1:0] state_out
);

   localparam logic [7:0] BEEP_INIT = 8'(BEEP_CYCLES);

   logic start_press;
   logic stop_press;
   logic door_sync;
   logic start_lvl_unused;
   logic stop_lvl_unused;
   logic door_edge_unused;

   button_sync #(.RESET_VAL(1'b1)) u_start_sync (
      .clock    (clock),
      .clearn   (clearn),
      .async_in (startn),
      .level    (start_lvl_unused),
      .press    (start_press)
   );

   button_sync #(.RESET_VAL(1'b1)) u_stop_sync (
      .clock    (clock),
      .clearn   (clearn),
      .async_in (stopn),
      .level    (stop_lvl_unused),
      .press    (stop_press)
   );

   button_sync #(.RESET_VAL(1'b0)) u_door_sync (
      .clock    (clock),
      .clearn   (clearn),
      .async_in (door_closed),
      .level    (door_sync),
      .press    (door_edge_unused)
   );

   state_t     state;
   state_t     state_nxt;
   logic [7:0] beep_cnt;
   logic [7:0] cnt_nxt;
   logic       clear_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = beep_cnt;
      clear_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (stop_press)
               clear_nxt = 1'b1;
            else if (start_press && door_sync && !timer_zero)
               state_nxt = COOK;
         end
         COOK: begin
            // End of cook outranks a simultaneous stop or door opening.
            if (timer_zero) begin
               state_nxt = DONE;
               cnt_nxt   = BEEP_INIT;
            end else if (stop_press || !door_sync) begin
               state_nxt = PAUSE;
            end
         end
         PAUSE: begin
            if (stop_press) begin
               state_nxt = IDLE;
               clear_nxt = 1'b1;
            end else if (start_press && door_sync) begin
               state_nxt = COOK;
            end
         end
         DONE: begin
            if (stop_press) begin
               state_nxt = IDLE;
               clear_nxt = 1'b1;
            end else if (beep_cnt <= 8'd1) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = beep_cnt - 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they move on the same edge.
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state       <= IDLE;
         beep_cnt    <= '0;
         mag_on      <= 1'b0;
         timer_loadn <= 1'b0;
         timer_clear <= 1'b0;
         beep        <= 1'b0;
      end else begin
         state       <= state_nxt;
         beep_cnt    <= cnt_nxt;
         mag_on      <= (state_nxt == COOK);
         timer_loadn <= (state_nxt != IDLE);
         timer_clear <= clear_nxt;
         beep        <= (state_nxt == DONE);
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_microwave_controller.sv
// Directed testbench for microwave_controller with hand-computed expectations.
module tb_microwave_controller;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COOK  = 3'd1;
   localparam logic [2:0] S_PAUSE = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;

   logic       clock;
   logic       clearn;
   logic       startn;
   logic       stopn;
   logic       door_closed;
   logic       timer_zero;
   logic       mag_on;
   logic       timer_loadn;
   logic       timer_clear;
   logic       beep;
   logic [2:0] state_out;

   int unsigned vectors;
   int unsigned miscompares;

   microwave_controller #(.BEEP_CYCLES(4)) dut (
      .clock       (clock),
      .clearn      (clearn),
      .startn      (startn),
      .stopn       (stopn),
      .door_closed (door_closed),
      .timer_zero  (timer_zero),
      .mag_on      (mag_on),
      .timer_loadn (timer_loadn),
      .timer_clear (timer_clear),
      .beep        (beep),
      .state_out   (state_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Press start for 3 cycles (enough for the press to take effect), then release.
   task automatic go_cook();
      startn = 1'b0;
      cyc(3);
      startn = 1'b1;
      cyc(2);
   endtask

   task automatic test_reset();
      clearn = 1'b0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; timer_zero = 1'b0;
      cyc(2);
      vectors++;
      if (state_out !== S_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", state_out, S_IDLE); end
      vectors++;
      if ({mag_on, timer_loadn, timer_clear, beep} !== 4'b0000) begin
         miscompares++; $display("FAIL reset_outputs: got %b expected 0000", {mag_on, timer_loadn, timer_clear, beep});
      end
      clearn = 1'b1;
      cyc(4);
      vectors++;
      if (state_out !== S_IDLE || mag_on !== 1'b0) begin
         miscompares++; $display("FAIL reset_release: state %0d mag %b expected 0/0", state_out, mag_on);
      end
   endtask

   task automatic test_start_held();
      startn = 1'b0;
      cyc(2);
      vectors++;
      if (state_out !== S_IDLE || mag_on !== 1'b0) begin
         miscompares++; $display("FAIL start_latency_n1: state %0d mag %b expected 0/0", state_out, mag_on);
      end
      cyc(1);
      vectors++;
      if (state_out !== S_COOK) begin miscompares++; $display("FAIL start_state: got %0d expected %0d", state_out, S_COOK); end
      vectors++;
      if ({mag_on, timer_loadn, timer_clear, beep} !== 4'b1100) begin
         miscompares++; $display("FAIL start_outputs: got %b expected 1100", {mag_on, timer_loadn, timer_clear, beep});
      end
      cyc(1);
      startn = 1'b1;
      cyc(3);
      vectors++;
      if (state_out !== S_COOK || mag_on !== 1'b1) begin
         miscompares++; $display("FAIL start_held_once: state %0d mag %b expected 1/1", state_out, mag_on);
      end
   endtask

   task automatic test_done_beep();
      timer_zero = 1'b1;
      cyc(1);
      vectors++;
      if (state_out !== S_DONE) begin miscompares++; $display("FAIL done_state: got %0d expected %0d", state_out, S_DONE); end
      vectors++;
      if ({mag_on, timer_loadn, beep} !== 3'b011) begin
         miscompares++; $display("FAIL done_outputs: got %b expected 011", {mag_on, timer_loadn, beep});
      end
      timer_zero = 1'b0;
      for (int i = 1; i < 4; i++) begin
         cyc(1);
         vectors++;
         if (beep !== 1'b1 || state_out !== S_DONE) begin
            miscompares++; $display("FAIL beep_hold_%0d: beep %b state %0d expected 1/3", i, beep, state_out);
         end
      end
      cyc(1);
      vectors++;
      if (state_out !== S_IDLE || beep !== 1'b0 || timer_loadn !== 1'b0) begin
         miscompares++; $display("FAIL beep_end: state %0d beep %b loadn %b expected 0/0/0", state_out, beep, timer_loadn);
      end
   endtask

   task automatic test_zero_priority();
      go_cook();
      stopn = 1'b0;
      cyc(2);
      timer_zero = 1'b1;
      cyc(1);
      vectors++;
      if (state_out !== S_DONE || beep !== 1'b1) begin
         miscompares++; $display("FAIL zero_beats_stop: state %0d beep %b expected 3/1", state_out, beep);
      end
      stopn = 1'b1;
      timer_zero = 1'b0;
      cyc(6);
      vectors++;
      if (state_out !== S_IDLE) begin miscompares++; $display("FAIL zero_prio_idle: got %0d expected %0d", state_out, S_IDLE); end
   endtask

   task automatic test_door_pause();
      go_cook();
      door_closed = 1'b0;
      cyc(2);
      vectors++;
      if (state_out !== S_COOK) begin miscompares++; $display("FAIL door_latency_n1: got %0d expected %0d", state_out, S_COOK); end
      cyc(1);
      vectors++;
      if (state_out !== S_PAUSE || mag_on !== 1'b0 || timer_loadn !== 1'b1) begin
         miscompares++; $display("FAIL door_pause: state %0d mag %b loadn %b expected 2/0/1", state_out, mag_on, timer_loadn);
      end
      go_cook();
      vectors++;
      if (state_out !== S_PAUSE) begin miscompares++; $display("FAIL start_door_open: got %0d expected %0d", state_out, S_PAUSE); end
      door_closed = 1'b1;
      cyc(3);
      go_cook();
      vectors++;
      if (state_out !== S_COOK || mag_on !== 1'b1) begin
         miscompares++; $display("FAIL resume_cook: state %0d mag %b expected 1/1", state_out, mag_on);
      end
   endtask

   task automatic test_stop_beats_start();
      stopn = 1'b0;
      cyc(3);
      vectors++;
      if (state_out !== S_PAUSE || timer_clear !== 1'b0) begin
         miscompares++; $display("FAIL stop_to_pause: state %0d clear %b expected 2/0", state_out, timer_clear);
      end
      stopn = 1'b1;
      cyc(2);
      startn = 1'b0; stopn = 1'b0;
      cyc(2);
      vectors++;
      if (state_out !== S_PAUSE) begin miscompares++; $display("FAIL both_latency_n1: got %0d expected %0d", state_out, S_PAUSE); end
      cyc(1);
      vectors++;
      if (state_out !== S_IDLE || timer_clear !== 1'b1 || mag_on !== 1'b0) begin
         miscompares++; $display("FAIL both_stop_wins: state %0d clear %b mag %b expected 0/1/0", state_out, timer_clear, mag_on);
      end
      cyc(1);
      vectors++;
      if (timer_clear !== 1'b0 || mag_on !== 1'b0 || state_out !== S_IDLE) begin
         miscompares++; $display("FAIL clear_one_cycle: clear %b mag %b state %0d expected 0/0/0", timer_clear, mag_on, state_out);
      end
      startn = 1'b1; stopn = 1'b1;
      cyc(2);
   endtask

   task automatic test_idle_zero();
      timer_zero = 1'b1;
      go_cook();
      vectors++;
      if (state_out !== S_IDLE || mag_on !== 1'b0) begin
         miscompares++; $display("FAIL idle_zero_start: state %0d mag %b expected 0/0", state_out, mag_on);
      end
      stopn = 1'b0;
      cyc(2);
      vectors++;
      if (timer_clear !== 1'b0) begin miscompares++; $display("FAIL idle_clear_early: got %b expected 0", timer_clear); end
      cyc(1);
      vectors++;
      if (timer_clear !== 1'b1 || state_out !== S_IDLE) begin
         miscompares++; $display("FAIL idle_clear_pulse: clear %b state %0d expected 1/0", timer_clear, state_out);
      end
      cyc(1);
      vectors++;
      if (timer_clear !== 1'b0) begin miscompares++; $display("FAIL idle_clear_drop: got %b expected 0", timer_clear); end
      stopn = 1'b1;
      timer_zero = 1'b0;
      cyc(2);
   endtask

   task automatic test_async_reset();
      go_cook();
      vectors++;
      if (state_out !== S_COOK || mag_on !== 1'b1) begin
         miscompares++; $display("FAIL pre_reset_cook: state %0d mag %b expected 1/1", state_out, mag_on);
      end
      @(negedge clock);
      clearn = 1'b0;
      #1;
      vectors++;
      if (mag_on !== 1'b0 || state_out !== S_IDLE || timer_loadn !== 1'b0) begin
         miscompares++; $display("FAIL async_reset: mag %b state %0d loadn %b expected 0/0/0", mag_on, state_out, timer_loadn);
      end
      cyc(2);
      @(negedge clock);
      clearn = 1'b1;
      cyc(5);
      vectors++;
      if (state_out !== S_IDLE || mag_on !== 1'b0) begin
         miscompares++; $display("FAIL post_reset_idle: state %0d mag %b expected 0/0", state_out, mag_on);
      end
      go_cook();
      vectors++;
      if (state_out !== S_COOK) begin miscompares++; $display("FAIL post_reset_start: got %0d expected %0d", state_out, S_COOK); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_start_held();
      test_done_beep();
      test_zero_priority();
      test_door_pause();
      test_stop_beats_start();
      test_idle_zero();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
